// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency external memory port between the
// I-cache refill path (reads only) and the D-cache path (reads and writes).
// One transaction at a time: IDLE (sample/grant) -> BUSY (strobe) -> DONE (ack).
// Configuration macro ARB_RR_EN: when defined, contention is resolved
// round-robin; when undefined, D always wins over I.
module mem_arbiter #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [WORD_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [WORD_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WORD_WIDTH-1:0] d_addr,
    input  logic [WORD_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [WORD_WIDTH-1:0] d_rdata,
    output logic                  busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
    logic                  r_owner_d,   w_owner_d_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic                  r_mem_read,  w_mem_read_nxt;
    logic                  r_mem_write, w_mem_write_nxt;
    logic [WORD_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [WORD_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [WORD_WIDTH-1:0] r_i_rdata,   w_i_rdata_nxt;
    logic [WORD_WIDTH-1:0] r_d_rdata,   w_d_rdata_nxt;
    logic                  r_i_ack,     w_i_ack_nxt;
    logic                  r_d_ack,     w_d_ack_nxt;
    logic                  w_pick_d;
`ifdef ARB_RR_EN
    logic                  r_rr_last_d, w_rr_last_d_nxt;
`endif

    // Winner selection when sampling in IDLE
`ifdef ARB_RR_EN
    assign w_pick_d = d_req && (!i_req || !r_rr_last_d);
`else
    assign w_pick_d = d_req;
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_owner_d   <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
`ifdef ARB_RR_EN
            r_rr_last_d <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner_d   <= w_owner_d_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_i_ack     <= w_i_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
`ifdef ARB_RR_EN
            r_rr_last_d <= w_rr_last_d_nxt;
`endif
        end
    end

    // Next-state and next-output logic; acks default low so they pulse once
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_owner_d_nxt   = r_owner_d;
        w_busy_nxt      = r_busy;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_i_ack_nxt     = 1'b0;
        w_d_ack_nxt     = 1'b0;
`ifdef ARB_RR_EN
        w_rr_last_d_nxt = r_rr_last_d;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_state_nxt     = S_BUSY;
                    w_cnt_nxt       = CNT_W'(MEM_LATENCY - 1);
                    w_owner_d_nxt   = w_pick_d;
                    w_busy_nxt      = 1'b1;
                    w_mem_read_nxt  = !(w_pick_d && d_we);
                    w_mem_write_nxt = w_pick_d && d_we;
                    w_mem_addr_nxt  = w_pick_d ? d_addr : i_addr;
                    w_mem_wdata_nxt = w_pick_d ? d_wdata : '0;
`ifdef ARB_RR_EN
                    w_rr_last_d_nxt = w_pick_d;
`endif
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    if (r_mem_read) begin
                        if (r_owner_d) begin
                            w_d_rdata_nxt = mem_rdata;
                        end else begin
                            w_i_rdata_nxt = mem_rdata;
                        end
                    end
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_i_ack_nxt     = !r_owner_d;
                    w_d_ack_nxt     = r_owner_d;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = r_busy;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level reference model
// (grant edge + fixed latency arithmetic) predicts every output each cycle;
// a second instance built with MEM_LATENCY=1 covers the short-latency case.
module tb_mem_arbiter;

    localparam int L = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_ack, d_ack, busy, mem_read, mem_write;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        i_req1 = 1'b0;
    logic [31:0] i_addr1 = '0;
    logic        d_req1 = 1'b0, d_we1 = 1'b0;
    logic [31:0] d_addr1 = '0, d_wdata1 = '0;
    logic        i_ack1, d_ack1, busy1, mem_read1, mem_write1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int n_cmp = 0;
    int n_fail = 0;
    int edge_cnt = 0;

    mem_arbiter #(.WORD_WIDTH(32), .MEM_LATENCY(L)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.WORD_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_rdata(d_rdata1), .busy(busy1),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Memory contents as a pure function of address
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory returns correct data only in the last strobe cycle
    int rd_run = 0, rd_run1 = 0;
    always @(posedge clk) begin
        rd_run  <= mem_read  ? rd_run + 1  : 0;
        rd_run1 <= mem_read1 ? rd_run1 + 1 : 0;
    end
    assign mem_rdata  = (mem_read  && rd_run  == L - 1) ? mem_f(mem_addr)  : ~mem_f(mem_addr);
    assign mem_rdata1 = (mem_read1 && rd_run1 == 0)     ? mem_f(mem_addr1) : ~mem_f(mem_addr1);

    // Reference model: a grant at edge g owns cycles g+1..g+L+1; next sample at g+L+2
    logic        m_valid = 1'b0, m_owner_d = 1'b0, m_we = 1'b0, m_rr_d = 1'b0;
    int          m_g = 0, m_next = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_irdata = '0, m_drdata = '0;
    logic        m_pick_d;
    assign m_pick_d = d_req && (!i_req || !RR || !m_rr_d);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_next <= 0; m_rr_d <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_irdata <= '0; m_drdata <= '0;
        end else begin
            if (m_valid && !m_we && edge_cnt == m_g + L) begin
                if (m_owner_d) m_drdata <= mem_f(m_addr);
                else           m_irdata <= mem_f(m_addr);
            end
            if (edge_cnt >= m_next && (i_req || d_req)) begin
                m_valid   <= 1'b1;
                m_g       <= edge_cnt;
                m_next    <= edge_cnt + L + 2;
                m_owner_d <= m_pick_d;
                m_we      <= m_pick_d && d_we;
                m_addr    <= m_pick_d ? d_addr : i_addr;
                m_wdata   <= m_pick_d ? d_wdata : 32'h0;
                m_rr_d    <= m_pick_d;
            end
        end
    end

    logic         e_strobe, e_ack;
    logic [4:0]   w_exp_ctl, w_obs_ctl;
    logic [127:0] w_exp_dat, w_obs_dat;
    assign e_strobe  = m_valid && (edge_cnt > m_g) && (edge_cnt <= m_g + L);
    assign e_ack     = m_valid && (edge_cnt == m_g + L + 1);
    assign w_exp_ctl = {e_strobe | e_ack, e_strobe & !m_we, e_strobe & m_we,
                        e_ack & !m_owner_d, e_ack & m_owner_d};
    assign w_exp_dat = {m_addr, m_wdata, m_irdata, m_drdata};
    assign w_obs_ctl = {busy, mem_read, mem_write, i_ack, d_ack};
    assign w_obs_dat = {mem_addr, mem_wdata, i_rdata, d_rdata};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++;
        if (w_obs_ctl !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl got=%b want=00000", w_obs_ctl);
        end
        n_cmp++;
        if (w_obs_dat !== 128'h0) begin
            n_fail++; $display("FAIL reset_dat got=%h want=0", w_obs_dat);
        end
        rst = 1'b0;
        repeat (2) begin
            tick();
            n_cmp++;
            if (w_obs_ctl !== w_exp_ctl) begin
                n_fail++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", edge_cnt, w_obs_ctl, w_exp_ctl);
            end
        end
    endtask

    task automatic test_i_read();
        int g, ack_c, rd_n;
        bit addr_ok;
        g = edge_cnt; ack_c = -1; rd_n = 0; addr_ok = 1'b1;
        i_addr = 32'h40; i_req = 1'b1;
        repeat (10) begin
            tick();
            n_cmp++;
            if (w_obs_ctl !== w_exp_ctl) begin
                n_fail++; $display("FAIL i_read_ctl cyc=%0d got=%b want=%b", edge_cnt, w_obs_ctl, w_exp_ctl);
            end
            n_cmp++;
            if (w_obs_dat !== w_exp_dat) begin
                n_fail++; $display("FAIL i_read_dat cyc=%0d got=%h want=%h", edge_cnt, w_obs_dat, w_exp_dat);
            end
            if (mem_read) begin
                rd_n++;
                if (mem_addr !== 32'h40) addr_ok = 1'b0;
            end
            if (i_ack) begin ack_c = edge_cnt; i_req = 1'b0; end
        end
        n_cmp++;
        if (ack_c != g + L + 1) begin
            n_fail++; $display("FAIL i_read_ack_cycle got=%0d want=%0d", ack_c - g, L + 1);
        end
        n_cmp++;
        if (rd_n != L) begin
            n_fail++; $display("FAIL i_read_strobe_len got=%0d want=%0d", rd_n, L);
        end
        n_cmp++;
        if (i_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL i_read_rdata got=%h want=12345678", i_rdata);
        end
        n_cmp++;
        if (!addr_ok) begin
            n_fail++; $display("FAIL i_read_addr got=other want=00000040");
        end
    endtask

    task automatic test_d_write();
        int g, ack_c, wr_n, rd_n;
        g = edge_cnt; ack_c = -1; wr_n = 0; rd_n = 0;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        repeat (10) begin
            tick();
            n_cmp++;
            if (w_obs_ctl !== w_exp_ctl) begin
                n_fail++; $display("FAIL d_write_ctl cyc=%0d got=%b want=%b", edge_cnt, w_obs_ctl, w_exp_ctl);
            end
            n_cmp++;
            if (w_obs_dat !== w_exp_dat) begin
                n_fail++; $display("FAIL d_write_dat cyc=%0d got=%h want=%h", edge_cnt, w_obs_dat, w_exp_dat);
            end
            if (mem_write) wr_n++;
            if (mem_read) rd_n++;
            if (d_ack) begin ack_c = edge_cnt; d_req = 1'b0; end
        end
        n_cmp++;
        if (ack_c != g + L + 1 || wr_n != L || rd_n != 0) begin
            n_fail++; $display("FAIL d_write_timing got=ack%0d/wr%0d/rd%0d want=ack%0d/wr%0d/rd0",
                               ack_c - g, wr_n, rd_n, L + 1, L);
        end
        n_cmp++;
        if (d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL d_write_rdata_held got=%h want=0", d_rdata);
        end
        d_we = 1'b0;
    endtask

    task automatic test_contention();
        int g, ia, da, ei, ed;
        logic [31:0] ia_addr, da_addr;
        ia_addr = $urandom; da_addr = $urandom;
        i_addr = ia_addr; d_addr = da_addr; d_we = 1'b0; d_wdata = $urandom;
        g = edge_cnt; ia = -1; da = -1;
        i_req = 1'b1; d_req = 1'b1;
        repeat (16) begin
            tick();
            n_cmp++;
            if (w_obs_ctl !== w_exp_ctl || w_obs_dat !== w_exp_dat) begin
                n_fail++; $display("FAIL contention_cycle cyc=%0d got=%b/%h want=%b/%h",
                                   edge_cnt, w_obs_ctl, w_obs_dat, w_exp_ctl, w_exp_dat);
            end
            if (i_ack) begin ia = edge_cnt - g; i_req = 1'b0; end
            if (d_ack) begin da = edge_cnt - g; d_req = 1'b0; end
        end
        // after the D write, round-robin's last owner is D, so I goes first
        if (RR) begin ei = L + 1; ed = 2 * L + 3; end
        else    begin ed = L + 1; ei = 2 * L + 3; end
        n_cmp++;
        if (ia != ei || da != ed) begin
            n_fail++; $display("FAIL contention_order got=i%0d/d%0d want=i%0d/d%0d", ia, da, ei, ed);
        end
        n_cmp++;
        if (i_rdata !== mem_f(ia_addr) || d_rdata !== mem_f(da_addr)) begin
            n_fail++; $display("FAIL contention_rdata got=%h/%h want=%h/%h",
                               i_rdata, d_rdata, mem_f(ia_addr), mem_f(da_addr));
        end
    endtask

    task automatic test_starvation();
        int n_d, n_i, cyc, last;
        bit d_gap, i_gap, alt_ok;
        n_d = 0; n_i = 0; cyc = 0; last = -1; d_gap = 0; i_gap = 0; alt_ok = 1'b1;
        i_addr = $urandom; i_req = 1'b1;
        d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom); d_req = 1'b1;
        while (n_d < 5 && cyc < 80) begin
            tick(); cyc++;
            n_cmp++;
            if (w_obs_ctl !== w_exp_ctl || w_obs_dat !== w_exp_dat) begin
                n_fail++; $display("FAIL starve_cycle cyc=%0d got=%b/%h want=%b/%h",
                                   edge_cnt, w_obs_ctl, w_obs_dat, w_exp_ctl, w_exp_dat);
            end
            if (d_gap) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom); d_gap = 0;
            end
            if (i_gap) begin i_req = 1'b1; i_addr = $urandom; i_gap = 0; end
            if (d_ack) begin
                n_d++; d_req = 1'b0; d_gap = 1;
                if (last == 1) alt_ok = 1'b0;
                last = 1;
            end
            if (i_ack) begin
                n_i++; i_req = 1'b0; i_gap = 1;
                if (last == 0) alt_ok = 1'b0;
                last = 0;
            end
        end
        n_cmp++;
        if (n_d != 5) begin
            n_fail++; $display("FAIL starve_timeout got=%0d want=5 D acks", n_d);
        end
        n_cmp++;
        if (RR ? (n_i != 5 || !alt_ok) : (n_i != 0)) begin
            n_fail++; $display("FAIL starve_grants got=%0d I acks alt=%0d want=%0d", n_i, alt_ok, RR ? 5 : 0);
        end
        d_req = 1'b0;
        repeat (16) begin
            tick();
            n_cmp++;
            if (w_obs_ctl !== w_exp_ctl || w_obs_dat !== w_exp_dat) begin
                n_fail++; $display("FAIL starve_drain cyc=%0d got=%b/%h want=%b/%h",
                                   edge_cnt, w_obs_ctl, w_obs_dat, w_exp_ctl, w_exp_dat);
            end
            if (i_ack) i_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int g2, ack_c, acks, rd_n;
        ack_c = -1; acks = 0; rd_n = 0;
        i_addr = $urandom; i_req = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (mem_read !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_prestrobe got=%b want=1", mem_read);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (w_obs_ctl !== 5'b0 || w_obs_dat !== 128'h0) begin
            n_fail++; $display("FAIL reset_mid_async got=%b/%h want=0/0", w_obs_ctl, w_obs_dat);
        end
        tick();
        rst = 1'b0;
        g2 = edge_cnt;
        repeat (10) begin
            tick();
            n_cmp++;
            if (w_obs_ctl !== w_exp_ctl || w_obs_dat !== w_exp_dat) begin
                n_fail++; $display("FAIL reset_mid_cycle cyc=%0d got=%b/%h want=%b/%h",
                                   edge_cnt, w_obs_ctl, w_obs_dat, w_exp_ctl, w_exp_dat);
            end
            if (mem_read) rd_n++;
            if (i_ack) begin acks++; ack_c = edge_cnt; i_req = 1'b0; end
        end
        n_cmp++;
        if (acks != 1 || ack_c != g2 + L + 1 || rd_n != L) begin
            n_fail++; $display("FAIL reset_mid_restart got=acks%0d/ack%0d/rd%0d want=acks1/ack%0d/rd%0d",
                               acks, ack_c - g2, rd_n, L + 1, L);
        end
    endtask

    task automatic test_latency1();
        int g, c, acks;
        logic [31:0] a;
        a = $urandom; acks = 0;
        i_addr1 = a; i_req1 = 1'b1; g = edge_cnt;
        repeat (6) begin
            tick();
            c = edge_cnt;
            n_cmp++;
            if (mem_read1 !== (c == g + 1) || i_ack1 !== (c == g + 2)) begin
                n_fail++; $display("FAIL lat1_ctl cyc=%0d got=rd%b/ack%b want=rd%b/ack%b",
                                   c - g, mem_read1, i_ack1, (c == g + 1), (c == g + 2));
            end
            n_cmp++;
            if (mem_addr1 !== a) begin
                n_fail++; $display("FAIL lat1_addr cyc=%0d got=%h want=%h", c - g, mem_addr1, a);
            end
            if (c == g + 1) i_addr1 = ~a;
            if (i_ack1) begin acks++; i_req1 = 1'b0; end
        end
        n_cmp++;
        if (acks != 1 || i_rdata1 !== mem_f(a)) begin
            n_fail++; $display("FAIL lat1_rdata got=%h acks=%0d want=%h acks=1", i_rdata1, acks, mem_f(a));
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            tick();
            n_cmp++;
            if (w_obs_ctl !== w_exp_ctl) begin
                n_fail++; $display("FAIL random_ctl cyc=%0d got=%b want=%b", edge_cnt, w_obs_ctl, w_exp_ctl);
            end
            n_cmp++;
            if (w_obs_dat !== w_exp_dat) begin
                n_fail++; $display("FAIL random_dat cyc=%0d got=%h want=%h", edge_cnt, w_obs_dat, w_exp_dat);
            end
            if (i_ack) i_req = 1'b0;
            else if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (d_ack) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_contention();
        test_starvation();
        test_reset_mid();
        test_latency1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
